// File: rtl/sprite_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_packer
//  Description : Packs 2-bit palette-index pixels into 32-bit sprite words
//                (pixel 0 in bits [31:30]) and presents them with sequential
//                sprite-RAM write addresses through a single-entry output
//                register.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_packer #(
    parameter int NUM_WORDS = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [1:0]        pix_data,
    input  logic              pix_last,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    logic [31:0]       r_acc;
    logic [3:0]        r_cnt;
    logic              r_valid;
    logic [31:0]       r_data;
    logic              r_last;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_done;

    logic [4:0]        w_shift;
    logic [31:0]       w_acc_next;
    logic              w_pix_acc;
    logic              w_word_acc;
    logic              w_complete;

    // Slot position of the incoming pixel and the accumulator including it.
    // A completing pixel stalls only while a held word is not being taken.
    always_comb begin
        w_shift    = 5'd30 - {r_cnt, 1'b0};
        w_acc_next = r_acc | ({30'd0, pix_data} << w_shift);
        pix_ready  = !r_valid || word_ready || ((r_cnt != 4'd15) && !pix_last);
        w_pix_acc  = pix_valid && pix_ready;
        w_word_acc = r_valid && word_ready;
        w_complete = w_pix_acc && ((r_cnt == 4'd15) || pix_last);
    end

    // Accumulator, output register, write-address counter and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= 32'd0;
            r_cnt     <= 4'd0;
            r_valid   <= 1'b0;
            r_data    <= 32'd0;
            r_last    <= 1'b0;
            r_wr_addr <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_word_acc && r_last;

            // The address counter always names the word currently held, so
            // it only moves when that word leaves.
            if (w_word_acc) begin
                if (r_last || (r_wr_addr == c_last_addr)) begin
                    r_wr_addr <= '0;
                end else begin
                    r_wr_addr <= r_wr_addr + c_addr_one;
                end
            end

            if (w_pix_acc) begin
                if (w_complete) begin
                    r_acc <= 32'd0;
                    r_cnt <= 4'd0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            // A new word may replace one being taken in the same cycle.
            if (w_complete) begin
                r_valid <= 1'b1;
                r_data  <= w_acc_next;
                r_last  <= pix_last;
            end else if (w_word_acc) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign word_valid = r_valid;
    assign word_data  = r_data;
    assign word_addr  = r_wr_addr;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_packer
//  Description : Self-checking bench for sprite_packer with a queue-based
//                reference model and literal scenario expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_packer;

    localparam int NW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [1:0]    pix_data = 2'd0;
    logic          pix_last = 1'b0;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [31:0]   word_data;
    logic [AW-1:0] word_addr;
    logic          done;

    sprite_packer #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_addr  (word_addr),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;
    bit rnd_wr   = 1'b0;
    int cyc      = 0;
    int pix_cnt  = 0;
    int done_cnt = 0;

    logic [31:0] log_d[$];
    int          log_a[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending pixels of the current word, held word, address.
    logic [1:0]  m_q[$];
    bit          m_held  = 1'b0;
    bit          m_hlast = 1'b0;
    bit          m_done  = 1'b0;
    logic [31:0] m_hword = 32'd0;
    int          m_addr  = 0;
    int          m_haddr = 0;

    function automatic bit exp_ready();
        return !m_held || word_ready || (m_q.size() != 15 && !pix_last);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_q.delete();
            m_held = 0; m_hlast = 0; m_done = 0; m_hword = 0; m_addr = 0; m_haddr = 0;
        end else begin
            bit pa, wa;
            logic [31:0] w;
            pa = pix_valid && exp_ready();
            wa = m_held && word_ready;
            m_done = wa && m_hlast;
            if (wa) begin
                m_addr = m_hlast ? 0 : (m_addr + 1) % NW;
                m_held = 0;
            end
            if (pa) begin
                m_q.push_back(pix_data);
                if (m_q.size() == 16 || pix_last) begin
                    w = 32'd0;
                    for (int k = 0; k < m_q.size(); k++)
                        w = w | (32'(m_q[k]) << (30 - 2 * k));
                    m_held  = 1;
                    m_hword = w;
                    m_hlast = pix_last;
                    m_haddr = m_addr;
                    m_q.delete();
                end
            end
        end
    end

    // Compare DUT against the model every cycle; log accepted words.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("word_valid", word_valid, m_held);
            if (m_held) begin
                chk("word_data", word_data, m_hword);
                chk("word_addr", word_addr, m_haddr);
            end
            chk("done", done, m_done);
            chk("pix_ready", pix_ready, exp_ready());
            if (done) done_cnt++;
            if (!reset && word_valid && word_ready) begin
                log_d.push_back(word_data);
                log_a.push_back(int'(word_addr));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_wr) word_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_pix(input logic [1:0] d, input logic l);
        bit acc;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                pix_valid = 1'b0;
                pix_last  = 1'b0;
                pix_cnt++;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL send_pix timeout: pixel not accepted after 300 cycles");
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_word_addr", word_addr, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        log_d.delete();
        log_a.delete();
        done_cnt = 0;
        pix_cnt  = 0;
    endtask

    task automatic chk_log(input int i, input logic [31:0] d, input int a);
        if (i < log_d.size()) begin
            chk($sformatf("log%0d_data", i), log_d[i], d);
            chk($sformatf("log%0d_addr", i), log_a[i], a);
        end else begin
            chk($sformatf("log%0d_missing", i), log_d.size(), i + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        chk_en = 1'b1;
        do_reset();

        // 16 pixels 0,1,2,3,... with word_ready=1, no stall
        word_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send_pix(2'(i % 4), 1'b0);
        chk("t1_cycles", cyc - c0, 16);
        idle(3);
        chk("t1_words", log_d.size(), 1);
        chk_log(0, 32'h1B1B1B1B, 0);

        // 5 pixels of 3, last on 5th; next word restarts at address 0
        do_reset();
        for (int i = 0; i < 5; i++) send_pix(2'd3, i == 4);
        idle(3);
        chk_log(0, 32'hFFC00000, 0);
        chk("t2_done", done_cnt, 1);
        for (int i = 0; i < 16; i++) send_pix(2'd0, 1'b0);
        idle(3);
        chk_log(1, 32'h00000000, 0);

        // word_ready low with 32 pixels offered back to back
        do_reset();
        word_ready = 1'b0;
        fork
            for (int i = 0; i < 32; i++) send_pix(2'd2, 1'b0);
            begin
                repeat (45) @(posedge clk);
                chk("t3_stalled_cnt", pix_cnt, 31);
                #1 word_ready = 1'b1;
            end
        join
        idle(3);
        chk("t3_words", log_d.size(), 2);
        chk_log(0, 32'hAAAAAAAA, 0);
        chk_log(1, 32'hAAAAAAAA, 1);

        // 80 pixels without pix_last: addresses wrap 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 80; i++) send_pix(2'((i * 7 + 1) % 4), 1'b0);
        idle(3);
        chk("t4_words", log_d.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t4_addr%0d", i), (i < log_a.size()) ? log_a[i] : -1, i % 4);
        chk("t4_done", done_cnt, 0);

        // pix_last on the 16th pixel gives exactly one word
        do_reset();
        for (int i = 0; i < 16; i++) send_pix(2'd1, i == 15);
        idle(5);
        chk("t5_words", log_d.size(), 1);
        chk_log(0, 32'h55555555, 0);
        chk("t5_done", done_cnt, 1);

        // reset after 7 pixels, then reset while a word is held
        do_reset();
        for (int i = 0; i < 7; i++) send_pix(2'd3, 1'b0);
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_pix(2'd3, 1'b0);
        idle(2);
        chk("t6_held", word_valid, 1);
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_pix(2'd1, 1'b0);
        idle(3);
        chk("t6_words", log_d.size(), 1);
        chk_log(0, 32'h55555555, 0);

        // randomized traffic against the model
        do_reset();
        rnd_wr = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_pix(2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0);
        end
        rnd_wr = 1'b0;
        #1 word_ready = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
